// File: rtl/rr_arbiter_8_if.sv
// rtl/rr_arbiter_8_if.sv - request/grant bundle between eight requesters and rr_arbiter_8
//
// Signals:
//   req        requester -> arbiter, bit i is requester i, held for the whole transaction
//   gnt        arbiter -> requester, registered one-hot grant, zero when idle
//   gnt_idx    arbiter -> requester, binary index of the granted requester, 0 when idle
//   gnt_valid  arbiter -> requester, high while any grant is active
//   timeout    arbiter -> requester, one-cycle pulse on a forced release
// Modports: master = requester side, slave = arbiter side.
interface rr_arbiter_8_if;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  modport master (
    output req,
    input  gnt,
    input  gnt_idx,
    input  gnt_valid,
    input  timeout
  );

  modport slave (
    input  req,
    output gnt,
    output gnt_idx,
    output gnt_valid,
    output timeout
  );
endinterface

// File: rtl/rr_arbiter_8.sv
// rtl/rr_arbiter_8.sv - eight-requester round-robin arbiter with registered one-hot grant
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset, drops any grant immediately
//   bus    rr_arbiter_8_if.slave: req in; gnt, gnt_idx, gnt_valid, timeout out
// Parameters:
//   TIMEOUT  maximum cycles a grant may be held (2..255), used with ARB_TIMEOUT_EN
//   CNT_W    hold counter width, 2**CNT_W must exceed TIMEOUT
// Optional feature macro: ARB_TIMEOUT_EN (forced release after TIMEOUT cycles).
module rr_arbiter_8 #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input logic           clk,
  input logic           rst_n,
  rr_arbiter_8_if.slave bus
);

  if (TIMEOUT < 2 || TIMEOUT > 255 || (1 << CNT_W) <= TIMEOUT) begin : g_bad_params
    $error("rr_arbiter_8: illegal TIMEOUT/CNT_W combination");
  end

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state;
  logic [2:0]       ptr;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       gnt_q;
  logic [2:0]       idx_q;
  logic             valid_q;

  // Rotating search: the first set request at or above ptr wins, wrapping 7->0.
  logic             found;
  logic [2:0]       winner;
  logic [2:0]       cand;

  always_comb begin
    found  = 1'b0;
    winner = 3'd0;
    cand   = 3'd0;
    for (int i = 0; i < 8; i++) begin
      cand = ptr + 3'(i);
      if (!found && bus.req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  logic timeout_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= 3'd0;
      cnt     <= '0;
      gnt_q   <= 8'h00;
      idx_q   <= 3'd0;
      valid_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (found) begin
            gnt_q   <= 8'h01 << winner;
            idx_q   <= winner;
            valid_q <= 1'b1;
            cnt     <= '0;
            state   <= GRANT;
          end
        end
        GRANT: begin
          // The served requester moves to the lowest priority slot on release.
          if (!bus.req[idx_q]) begin
            gnt_q   <= 8'h00;
            idx_q   <= 3'd0;
            valid_q <= 1'b0;
            ptr     <= idx_q + 3'd1;
            state   <= IDLE;
          end
`ifdef ARB_TIMEOUT_EN
          else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            gnt_q     <= 8'h00;
            idx_q     <= 3'd0;
            valid_q   <= 1'b0;
            ptr       <= idx_q + 3'd1;
            state     <= IDLE;
            timeout_q <= 1'b1;
          end
`endif
          else if (cnt != {CNT_W{1'b1}}) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_idx   = idx_q;
  assign bus.gnt_valid = valid_q;
`ifdef ARB_TIMEOUT_EN
  assign bus.timeout   = timeout_q;
`else
  assign bus.timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arbiter_8.sv
// tb/tb_rr_arbiter_8.sv - self-checking bench for rr_arbiter_8 against a rotation model
module tb_rr_arbiter_8;
  localparam int TMO = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
  localparam int N_HOLD = TMO - 1;
`else
  localparam bit TO_EN = 1'b0;
  localparam int N_HOLD = 10;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  // Model: who owns the resource, how many cycles it has held it, where rotation resumes.
  int   m_owner = -1;
  int   m_hold = 0;
  int   m_ptr = 0;
  logic m_to = 1'b0;

  rr_arbiter_8_if bus ();

  rr_arbiter_8 #(.TIMEOUT(TMO), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] exp_gnt();
    return (m_owner < 0) ? 8'h00 : 8'(1 << m_owner);
  endfunction

  function automatic logic [2:0] exp_idx();
    return (m_owner < 0) ? 3'd0 : 3'(m_owner);
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_hold  = 0;
    m_ptr   = 0;
    m_to    = 1'b0;
  endtask

  // Present r for one clock edge, advance the model, then settle 1 time unit past the edge.
  task automatic cycle(input logic [7:0] r);
    bit got;
    bus.req = r;
    @(posedge clk);
    m_to = 1'b0;
    if (m_owner < 0) begin
      got = 1'b0;
      for (int k = 0; k < 8; k++) begin
        if (!got && r[(m_ptr + k) % 8]) begin
          got     = 1'b1;
          m_owner = (m_ptr + k) % 8;
          m_hold  = 1;
        end
      end
    end else if (!r[m_owner]) begin
      m_ptr   = (m_owner + 1) % 8;
      m_owner = -1;
    end else if (TO_EN && m_hold == TMO) begin
      m_ptr   = (m_owner + 1) % 8;
      m_owner = -1;
      m_to    = 1'b1;
    end else begin
      m_hold++;
    end
    #1;
  endtask

  task automatic test_reset();
    bus.req = 8'hFF;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (bus.gnt !== 8'h00 || bus.gnt_idx !== 3'd0 || bus.gnt_valid !== 1'b0 || bus.timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: gnt=%h idx=%0d valid=%b to=%b, need 00/0/0/0", bus.gnt, bus.gnt_idx, bus.gnt_valid, bus.timeout);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.gnt !== 8'h00 || bus.gnt_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_held: gnt=%h valid=%b, need 00/0", bus.gnt, bus.gnt_valid);
    end
    rst_n = 1'b1;
    cycle(8'hFF);
    n_checks++;
    if (bus.gnt !== 8'h01 || bus.gnt_idx !== 3'd0 || bus.gnt_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL first_grant: gnt=%h idx=%0d valid=%b, need 01/0/1", bus.gnt, bus.gnt_idx, bus.gnt_valid);
    end
  endtask

  task automatic test_rotation();
    for (int g = 0; g < 9; g++) begin
      n_checks++;
      if (bus.gnt_idx !== 3'(g % 8) || bus.gnt !== 8'(1 << (g % 8)) || bus.gnt_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL rotation_order[%0d]: gnt=%h idx=%0d, need idx %0d", g, bus.gnt, bus.gnt_idx, g % 8);
      end
      cycle(8'hFF);
      cycle(8'hFF);
      cycle(8'hFF & ~8'(1 << (g % 8)));
      n_checks++;
      if (bus.gnt_valid !== 1'b0 || bus.gnt !== 8'h00 || bus.gnt_idx !== 3'd0) begin
        n_fail++;
        $display("FAIL rotation_idle[%0d]: gnt=%h idx=%0d valid=%b, need idle", g, bus.gnt, bus.gnt_idx, bus.gnt_valid);
      end
      cycle(8'hFF);
    end
  endtask

  task automatic test_wrap_skip();
    cycle(8'h00);
    cycle(8'h20);
    cycle(8'h00);
    cycle(8'h05);
    n_checks++;
    if (bus.gnt_idx !== 3'd0 || bus.gnt !== 8'h01) begin
      n_fail++;
      $display("FAIL wrap_from_ptr6: gnt=%h idx=%0d, need 01/0", bus.gnt, bus.gnt_idx);
    end
    cycle(8'h04);
    cycle(8'h04);
    n_checks++;
    if (bus.gnt_idx !== 3'd2 || bus.gnt !== 8'h04) begin
      n_fail++;
      $display("FAIL skip_to_idx2: gnt=%h idx=%0d, need 04/2", bus.gnt, bus.gnt_idx);
    end
  endtask

  task automatic test_hold_stability();
    cycle(8'h00);
    cycle(8'h08);
    for (int c = 0; c < N_HOLD; c++) begin
      n_checks++;
      if (bus.gnt !== 8'h08 || bus.gnt_idx !== 3'd3) begin
        n_fail++;
        $display("FAIL hold_stable[%0d]: gnt=%h idx=%0d, need 08/3", c, bus.gnt, bus.gnt_idx);
      end
      cycle({4'($urandom), 4'b1000});
    end
    n_checks++;
    if (bus.gnt !== 8'h08) begin
      n_fail++;
      $display("FAIL hold_stable_end: gnt=%h, need 08", bus.gnt);
    end
    cycle(8'h00);
  endtask

  task automatic test_mid_grant_reset();
    cycle(8'h00);
    cycle(8'h10);
    n_checks++;
    if (bus.gnt !== 8'h10 || bus.gnt_idx !== 3'd4) begin
      n_fail++;
      $display("FAIL pre_reset_grant: gnt=%h idx=%0d, need 10/4", bus.gnt, bus.gnt_idx);
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (bus.gnt !== 8'h00 || bus.gnt_valid !== 1'b0 || bus.gnt_idx !== 3'd0) begin
      n_fail++;
      $display("FAIL async_reset_drop: gnt=%h valid=%b idx=%0d, need 00/0/0", bus.gnt, bus.gnt_valid, bus.gnt_idx);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle(8'h30);
    n_checks++;
    if (bus.gnt_idx !== 3'd4 || bus.gnt !== 8'h10) begin
      n_fail++;
      $display("FAIL post_reset_ptr0: gnt=%h idx=%0d, need 10/4", bus.gnt, bus.gnt_idx);
    end
  endtask

  task automatic test_timeout();
    cycle(8'h00);
    cycle(8'h06);
    for (int c = 0; c < TMO; c++) begin
      n_checks++;
      if (bus.gnt_idx !== 3'd1 || bus.gnt !== 8'h02 || bus.timeout !== 1'b0) begin
        n_fail++;
        $display("FAIL timeout_hold[%0d]: gnt=%h idx=%0d to=%b, need 02/1/0", c, bus.gnt, bus.gnt_idx, bus.timeout);
      end
      cycle(8'h06);
    end
`ifdef ARB_TIMEOUT_EN
    n_checks++;
    if (bus.timeout !== 1'b1 || bus.gnt !== 8'h00) begin
      n_fail++;
      $display("FAIL timeout_pulse: to=%b gnt=%h, need 1/00", bus.timeout, bus.gnt);
    end
    cycle(8'h06);
    n_checks++;
    if (bus.timeout !== 1'b0 || bus.gnt_idx !== 3'd2 || bus.gnt !== 8'h04) begin
      n_fail++;
      $display("FAIL timeout_next: to=%b gnt=%h idx=%0d, need 0/04/2", bus.timeout, bus.gnt, bus.gnt_idx);
    end
`else
    for (int c = 0; c < 12; c++) begin
      n_checks++;
      if (bus.gnt_idx !== 3'd1 || bus.gnt !== 8'h02 || bus.timeout !== 1'b0) begin
        n_fail++;
        $display("FAIL no_timeout_hold[%0d]: gnt=%h idx=%0d to=%b, need 02/1/0", c, bus.gnt, bus.gnt_idx, bus.timeout);
      end
      cycle(8'h06);
    end
`endif
    cycle(8'h00);
  endtask

  // Sticky random requests: each bit flips with probability 1/4 per cycle.
  task automatic test_random();
    logic [7:0] r;
    r = 8'($urandom);
    for (int c = 0; c < 600; c++) begin
      for (int b = 0; b < 8; b++) begin
        if ($urandom_range(3) == 0) r[b] = ~r[b];
      end
      if ($urandom_range(15) == 0) r = 8'h00;
      cycle(r);
      n_checks++;
      if (bus.gnt !== exp_gnt() || bus.gnt_idx !== exp_idx() || bus.gnt_valid !== (m_owner >= 0) || bus.timeout !== m_to) begin
        n_fail++;
        $display("FAIL random[%0d] req=%h: gnt=%h idx=%0d valid=%b to=%b, need gnt=%h idx=%0d valid=%b to=%b",
                 c, r, bus.gnt, bus.gnt_idx, bus.gnt_valid, bus.timeout, exp_gnt(), exp_idx(), m_owner >= 0, m_to);
      end
    end
  endtask

  initial begin
    bus.req = 8'h00;
    test_reset();
    test_rotation();
    test_wrap_skip();
    test_hold_stability();
    test_mid_grant_reset();
    test_timeout();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_8.md
Name: rr_arbiter_8

Overview:
- Eight-requester round-robin arbiter that shares one downstream resource, such as a bus slot or a shared datapath unit.
- Produces a registered one-hot grant plus its 3-bit binary index.
- The index is the same encoding as the team's 8x3 encoder, so downstream muxes select directly on it.
- Requesters hold req high for the whole transaction and drop it to release the resource.

Parameters:
- TIMEOUT, default 16: maximum cycles a grant may be held. Used only when ARB_TIMEOUT_EN is defined. Legal range 2..255.
- CNT_W, default 8: width of the hold counter. Must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  8  request vector; bit i is requester i.
- gnt  output  8  registered one-hot grant; all zero when idle.
- gnt_idx  output  3  binary index of the granted requester; 3'b000 when idle.
- gnt_valid  output  1  high while any grant is active. Equals |gnt.
- timeout  output  1  one-cycle pulse on forced release. Constant 0 when ARB_TIMEOUT_EN is undefined.

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: gnt=8'h00, gnt_idx=3'd0, gnt_valid=0, timeout=0.
  - Internal: state=IDLE, priority pointer ptr=3'd0, hold counter=0.
  - Reset mid-grant drops the grant immediately (asynchronously) and does not wait for a clock edge.
- FSM states: IDLE, GRANT.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise, select the first set bit of req searching upward from ptr, wrapping 7->0.
  - On the next edge: gnt=onehot(winner), gnt_idx=winner, gnt_valid=1, state=GRANT, counter=0.
  - Latency is 1 cycle from req sampled to gnt visible.
- GRANT:
  - While req[gnt_idx]=1, hold gnt stable and increment the counter, saturating at all ones.
  - Changes on the other req bits are ignored.
  - When req[gnt_idx]=0 at an edge: gnt=0, gnt_valid=0, gnt_idx=0, ptr=gnt_idx+1 (mod 8, so 7 wraps to 0), state=IDLE.
  - There is always exactly one idle cycle between consecutive grants.
- Fairness: a requester that was just served has the lowest priority at the next arbitration. Any continuously asserted request is granted within 7 other grants.
- Simultaneous requests in IDLE: rotation order from ptr decides; no other priority applies.
- A request that rises and falls while another requester holds the grant is lost. The arbiter does not latch requests.
- gnt is always zero or one-hot. gnt_idx always matches gnt.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - In GRANT, if the counter reaches TIMEOUT-1 while req[gnt_idx] is still 1, force a release on that edge. Apply the same updates as a normal release (gnt=0, ptr=gnt_idx+1, state=IDLE) and set timeout=1 for one cycle.
  - A requester that still holds req high is re-granted only when rotation returns to it.
  - Release by the requester in the same cycle as expiry counts as a normal release, with timeout=0.
- Undefined: no counter limit applies, and the timeout output is tied to 0.

Test Plan:
- Reset check: rst_n=0 with req=8'hFF -> gnt=0, gnt_idx=0, gnt_valid=0. Release reset, keep req=8'hFF -> one cycle later gnt=8'h01, gnt_idx=0.
- Rotation: hold req=8'hFF; each owner drops its own bit for one cycle after 3 cycles, then re-raises it -> grant order idx 0,1,2,...,7,0. One idle cycle appears between grants.
- Wrap and skip: ptr=6 (after serving idx 5), req=8'b0000_0101 -> gnt_idx=0; after release -> gnt_idx=2.
- Hold stability: owner idx 3 holds req for 10 cycles while req[7:4] toggles randomly -> gnt stays 8'h08 for all 10 cycles.
- Mid-grant reset: idx 4 granted, assert rst_n=0 between edges -> gnt falls to 0 immediately. After reset, req=8'h30 -> gnt_idx=4 (ptr was reset to 0).
- ARB_TIMEOUT_EN with TIMEOUT=4 and req=8'h06 held -> idx 1 granted for 4 cycles, then timeout=1 for one cycle, then idx 2 granted. With the macro undefined -> idx 1 is held indefinitely and timeout stays 0.
